onehot_drain_encoder: RTL
=========================

# onehot_drain_encoder

Sequential 8-to-3 encoder, the inverse of the team's 3-to-8 one-hot decoder. Accepts an 8-bit request vector over a valid/ready handshake and emits the binary index of every set bit, lowest index first, one index per accepted output beat. It sits between request-collection logic and any consumer that addresses resources by 3-bit select, such as the decoder itself.

## Interface
Parameters:
- N, 8, request vector width.
- W, 3, index width; 2**W must equal N.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous reset, active-high, sampled on rising clk.
- in_valid  input  1  in_vec is valid.
- in_ready  output  1  block can capture a vector; equals (state == IDLE).
- in_vec  input  N  request vector; any number of bits may be set.
- out_valid  output  1  out_idx is valid; equals (state == DRAIN).
- out_ready  input  1  consumer accepts out_idx.
- out_idx  output  W  index of the lowest set bit of pending; 0 when pending == 0.
- out_last  output  1  pending has exactly one bit set; qualified by out_valid.
- zero_drop  output  1  registered one-cycle pulse: an all-zero vector was accepted and discarded.

## Operation
- Internal state: 2-state FSM {IDLE, DRAIN} and an N-bit register `pending`.
- IDLE, in_valid=1, in_vec != 0: pending <= in_vec, go to DRAIN.
- IDLE, in_valid=1, in_vec == 0: vector is consumed and no output is produced. Stay in IDLE. zero_drop=1 next cycle.
- IDLE, in_valid=0: hold.
- DRAIN, out_ready=1: clear pending[out_idx]. If out_last=1, go to IDLE. Otherwise stay in DRAIN.
- DRAIN, out_ready=0: pending, out_idx and out_last hold stable (AXI-style: out_valid never drops without a handshake).
- out_idx comes from a priority encode of pending, lowest bit wins, e.g. 8'b1010_0100 -> 2, then 5, then 7.
- in_vec is ignored outside an IDLE handshake. Changes to in_vec during DRAIN have no effect.
- Reset from any state, including mid-drain: state=IDLE, pending=0, zero_drop=0. The partially drained vector is lost and no further beats are emitted.

## Timing
- Values after reset: in_ready=1, out_valid=0, out_idx=0, out_last=0, zero_drop=0.
- Latency: input handshake at edge t -> out_valid=1 with the first index in the cycle after t.
- Throughput: one index per cycle while out_ready=1. A vector with k set bits occupies k+1 cycles from its input handshake to the next possible input handshake.
- No same-cycle bypass: in_ready rises only in the cycle after the last output handshake.
- All state changes happen on rising clk. in_ready, out_valid, out_idx and out_last are combinational functions of registered state only; there is no input-to-output combinational path.
- rst has priority over all handshakes in the same cycle.

## Test plan
- Single bit: rst, then in_vec=8'h10 with in_valid=1 for 1 cycle, out_ready=1 -> next cycle out_valid=1, out_idx=4, out_last=1; following cycle out_valid=0, in_ready=1.
- Multi-bit drain: in_vec=8'hA4, out_ready=1 -> out_idx sequence 2, 5, 7 on consecutive cycles with out_last=0, 0, 1; in_ready=0 throughout the drain.
- Backpressure: in_vec=8'h81, out_ready=0 for 3 cycles then 1 -> out_idx=0 held stable for 3 cycles, then 0 followed by 7; in_valid pulses with in_vec=8'hFF during the drain are ignored.
- Zero vector: in_vec=8'h00 with in_valid=1 -> zero_drop=1 for exactly 1 cycle, out_valid stays 0, in_ready stays 1.
- Full vector and back-to-back: in_vec=8'hFF then 8'h01, in_valid held high, out_ready=1 -> indices 0..7 over 8 cycles, 1 idle cycle, then index 0 with out_last=1.
- Reset mid-drain: in_vec=8'hF0, assert rst after index 5 has been emitted -> next cycle out_valid=0, in_ready=1, and indices 6 and 7 never appear.

Source files
------------

// File: rtl/onehot_drain_encoder.sv
// Sequential 8-to-3 encoder: captures a request vector and emits the index of
// each set bit, lowest first, one per accepted output beat.
module onehot_drain_encoder #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_vec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_last,
    output logic         zero_drop
);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    state_t       state_q, state_d;
    logic [N-1:0] pending_q, pending_d;
    logic         zero_drop_q, zero_drop_d;

    // Reset discards any partially drained vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            zero_drop_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            zero_drop_q <= zero_drop_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        zero_drop_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_vec != '0) begin
                        pending_d = in_vec;
                        state_d   = DRAIN;
                    end else begin
                        zero_drop_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    // Clearing the lowest set bit is the same as clearing pending[out_idx].
                    pending_d = pending_q & (pending_q - ONE);
                    if (out_last) begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DRAIN);
        zero_drop = zero_drop_q;
        out_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                out_idx = W'(i);
            end
        end
        out_last = out_valid && (pending_q != '0) && ((pending_q & (pending_q - ONE)) == '0);
    end

endmodule
